timer_keypad_ctrl: RTL

Front-panel controller that sits directly upstream of the min:sec countdown timer. It synchronizes and debounces a 10-key digit keypad plus start/stop buttons. Each accepted digit becomes a `data` value with a `loadn` low pulse, so the timer shifts the digit in. A run-state FSM drives the timer's `enable` and `clrn` inputs and reacts to the timer's `zero` flag.

---
 rtl/timer_keypad_ctrl_if.sv | 25 ++
 rtl/timer_keypad_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_keypad_ctrl_if.sv
// Timer-side link of the keypad controller: digit/load strobe, run control
// and the timer's zero flag.
interface timer_keypad_ctrl_if;
    logic [3:0] data;
    logic       loadn;
    logic       enable;
    logic       timer_clrn;
    logic       zero;

    modport master (
        output data,
        output loadn,
        output enable,
        output timer_clrn,
        input  zero
    );

    modport slave (
        input  data,
        input  loadn,
        input  enable,
        input  timer_clrn,
        output zero
    );
endinterface

// File: rtl/timer_keypad_ctrl.sv
// Keypad/start/stop front panel for the min:sec countdown timer.
// Define TIMER_KEY_DEBOUNCE_EN to build the debouncers; without it the debounced value is the synchronized sample.
module timer_keypad_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int LOAD_CYCLES     = 2,
    parameter int MAX_DIGITS      = 3
) (
    input  logic                        clock,
    input  logic                        clrn,
    input  logic [9:0]                  keys_i,
    input  logic                        start_i,
    input  logic                        stop_i,
    output logic                        done_o,
    output logic [1:0]                  digits_o,
    timer_keypad_ctrl_if.master         timer
);

    localparam int NIN = 12;
    localparam logic [3:0] LOAD_INIT = 4'(LOAD_CYCLES);
    localparam logic [1:0] MAX_D     = 2'(MAX_DIGITS);

    // Parameter ranges are checked at elaboration; digits_o is only two bits wide.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : gBadDebounce
        $error("DEBOUNCE_CYCLES must be 1..255");
    end
    if (LOAD_CYCLES < 1 || LOAD_CYCLES > 15) begin : gBadLoad
        $error("LOAD_CYCLES must be 1..15");
    end
    if (MAX_DIGITS < 1 || MAX_DIGITS > 3) begin : gBadDigits
        $error("MAX_DIGITS must be 1..3");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        PAUSED,
        DONE
    } state_t;

    logic [NIN-1:0] rawIn;
    logic [NIN-1:0] sync1_q;
    logic [NIN-1:0] sync2_q;
    logic [NIN-1:0] deb;
    logic [NIN-1:0] debPrev_q;

    assign rawIn = {stop_i, start_i, keys_i};

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= rawIn;
            sync2_q <= sync1_q;
        end
    end

`ifdef TIMER_KEY_DEBOUNCE_EN
    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [NIN-1:0]      deb_q;
    logic [NIN-1:0][7:0] debCnt_q;

    // A bit flips only after the sample has disagreed DEBOUNCE_CYCLES edges in a row.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            deb_q    <= '0;
            debCnt_q <= '0;
        end else begin
            for (int i = 0; i < NIN; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    debCnt_q[i] <= '0;
                end else if (debCnt_q[i] == DEB_LAST) begin
                    deb_q[i]    <= sync2_q[i];
                    debCnt_q[i] <= '0;
                end else begin
                    debCnt_q[i] <= debCnt_q[i] + 8'd1;
                end
            end
        end
    end

    assign deb = deb_q;
`else
    assign deb = sync2_q;
`endif

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            debPrev_q <= '0;
        end else begin
            debPrev_q <= deb;
        end
    end

    logic [9:0] debKeys;
    logic       keysOneHot;
    logic       keyEvent;
    logic       startEvent;
    logic       stopEvent;
    logic [3:0] keyDigit;

    // A digit needs an all-zero previous vector, so a held or multi-key press fires at most once.
    assign debKeys    = deb[9:0];
    assign keysOneHot = (debKeys != '0) && ((debKeys & (debKeys - 10'd1)) == '0);
    assign keyEvent   = (debPrev_q[9:0] == '0) && keysOneHot;
    assign startEvent = deb[10] & ~debPrev_q[10];
    assign stopEvent  = deb[11] & ~debPrev_q[11];

    always_comb begin
        keyDigit = '0;
        for (int i = 0; i < 10; i++) begin
            if (debKeys[i]) begin
                keyDigit = 4'(i);
            end
        end
    end

    state_t     state_q;
    logic [3:0] data_q;
    logic [3:0] loadCnt_q;
    logic       loadn_q;
    logic       enable_q;
    logic       timerClrn_q;
    logic       done_q;
    logic [1:0] digits_q;

    // Event priority is stop, then start, then digit; a digit while loadn is low is dropped.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state_q     <= IDLE;
            data_q      <= '0;
            loadCnt_q   <= '0;
            loadn_q     <= 1'b1;
            enable_q    <= 1'b0;
            timerClrn_q <= 1'b1;
            done_q      <= 1'b0;
            digits_q    <= '0;
        end else begin
            timerClrn_q <= 1'b1;

            if (!loadn_q) begin
                if (loadCnt_q == 4'd1) begin
                    loadn_q   <= 1'b1;
                    loadCnt_q <= '0;
                end else begin
                    loadCnt_q <= loadCnt_q - 4'd1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (stopEvent) begin
                        timerClrn_q <= 1'b0;
                        digits_q    <= '0;
                    end else if (startEvent) begin
                        if (digits_q != '0) begin
                            state_q  <= RUNNING;
                            enable_q <= 1'b1;
                        end
                    end else if (keyEvent && loadn_q && (digits_q < MAX_D)) begin
                        data_q    <= keyDigit;
                        loadn_q   <= 1'b0;
                        loadCnt_q <= LOAD_INIT;
                        digits_q  <= digits_q + 2'd1;
                    end
                end
                RUNNING: begin
                    if (stopEvent) begin
                        state_q  <= PAUSED;
                        enable_q <= 1'b0;
                    end else if (timer.zero) begin
                        state_q  <= DONE;
                        enable_q <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                PAUSED: begin
                    if (stopEvent) begin
                        state_q     <= IDLE;
                        timerClrn_q <= 1'b0;
                        digits_q    <= '0;
                    end else if (startEvent) begin
                        state_q  <= RUNNING;
                        enable_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (stopEvent || keyEvent) begin
                        state_q     <= IDLE;
                        timerClrn_q <= 1'b0;
                        done_q      <= 1'b0;
                        digits_q    <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign timer.data       = data_q;
    assign timer.loadn      = loadn_q;
    assign timer.enable     = enable_q;
    assign timer.timer_clrn = timerClrn_q;
    assign done_o           = done_q;
    assign digits_o         = digits_q;

endmodule
